// File: rtl/accel_if_pkg.sv
// Shared types and constants for the PS/PL control handshake sequencer.
package accel_if_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        RD_ADDR,
        RD_CAP,
        RD_OUT,
        RELEASE,
        DONE
    } state_e;

    localparam int unsigned CTRL_RUN_BIT  = 0;
    localparam int unsigned STAT_DONE_BIT = 0;
    localparam int unsigned ADDR_STEP     = 4;
    localparam logic [3:0]  BRAM_WE_ALL   = 4'hF;

endpackage

// File: rtl/handshake_timer.sv
// Down-counter bounding how long the sequencer waits for a pl_status edge.
module handshake_timer #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);
    // Loading TIMEOUT-1 makes the wait state last exactly TIMEOUT cycles.
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign expired = enable && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/accel_host_sequencer.sv
// Initiator side of the ps_control/pl_status handshake: load input BRAM, kick the
// accelerator, drain the output BRAM onto a stream, then release the handshake.
module accel_host_sequencer
    import accel_if_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IN_WORDS  = 512,
    parameter int unsigned OUT_WORDS = 2,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] in_addr,
    output logic [DATA_W-1:0] in_wdata,
    output logic [3:0]        in_wren,
    output logic [31:0]       ps_control,
    input  logic [31:0]       pl_status,
    output logic [ADDR_W-1:0] out_addr,
    input  logic [DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int unsigned MAX_WORDS = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS) + 1;
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_WORDS - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_WORDS - 1);

    if (IN_WORDS * ADDR_STEP > (32'd1 << ADDR_W)) begin : g_cfg_check
        $error("IN_WORDS does not fit in the input BRAM address space");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic               err_q, err_d;
    logic               stale_q, stale_d;
    logic               stat_done, run, in_accept, tmr_expired, tmr_clear, tmr_enable;
    logic [31:0]        unused_status;

    assign unused_status = pl_status;
    assign stat_done     = pl_status[STAT_DONE_BIT];

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        m_data_d  = m_data_q;
        err_d     = err_q;
        stale_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // A status still high from a previous job means the block is not ready.
                    if (stat_done) begin
                        err_d   = 1'b1;
                        stale_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        in_cnt_d = '0;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (s_valid) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == IN_LAST) state_d = KICK;
                end
            end
            KICK: begin
                if (stat_done) begin
                    out_cnt_d = '0;
                    state_d   = RD_ADDR;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end
            end
            RD_ADDR: state_d = RD_CAP;
            RD_CAP: begin
                m_data_d = out_rdata;
                state_d  = RD_OUT;
            end
            RD_OUT: begin
                if (m_ready) begin
                    if (out_cnt_q == OUT_LAST) begin
                        state_d = RELEASE;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RELEASE: begin
                if (!stat_done) begin
                    state_d = DONE;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run        = state_q inside {KICK, RD_ADDR, RD_CAP, RD_OUT};
        in_accept  = (state_q == LOAD) && s_valid;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE) || stale_q;
        err        = err_q;
        s_ready    = (state_q == LOAD);
        in_wren    = in_accept ? BRAM_WE_ALL : 4'h0;
        in_addr    = in_accept ? ADDR_W'(in_cnt_q * ADDR_STEP) : '0;
        in_wdata   = in_accept ? s_data : '0;
        out_addr   = (state_q == RD_ADDR) ? ADDR_W'(out_cnt_q * ADDR_STEP) : '0;
        m_valid    = (state_q == RD_OUT);
        m_data     = m_data_q;
        ps_control = '0;
        ps_control[CTRL_RUN_BIT] = run;
        tmr_enable = state_q inside {KICK, RELEASE};
        // Reload on every state change so KICK and RELEASE each get a full window.
        tmr_clear  = (state_d != state_q);
    end

    handshake_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
            stale_q   <= stale_d;
        end
    end

endmodule

// File: tb/tb_accel_host_sequencer.sv
// Directed bench for accel_host_sequencer with BRAM and pl_status responder models.
module tb_accel_host_sequencer;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset, start, s_valid, m_ready;
    logic              busy, done, err, s_ready, m_valid;
    logic [DATA_W-1:0] s_data, in_wdata, m_data;
    logic [DATA_W-1:0] out_rdata = '0;
    logic [ADDR_W-1:0] in_addr, out_addr;
    logic [3:0]        in_wren;
    logic [31:0]       ps_control, pl_status;

    accel_host_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .IN_WORDS  (4),
        .OUT_WORDS (2),
        .TIMEOUT   (50)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_wren    (in_wren),
        .ps_control (ps_control),
        .pl_status  (pl_status),
        .out_addr   (out_addr),
        .out_rdata  (out_rdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Models: output BRAM with 1-cycle read, pl_status responder.
    logic [31:0] out_mem [4];
    logic [31:0] in_words [4];
    logic [31:0] exp_out [2];
    int          resp_mode = 0;   // 0: nominal, 1: never, 2: rise on the timeout cycle
    logic        resp_q = 1'b0;
    logic        stale_force = 1'b0;
    int          hi_cnt = 0, lo_cnt = 0;

    assign pl_status = {31'b0, resp_q | stale_force};

    always @(posedge clk) begin
        out_rdata <= out_mem[out_addr[3:2]];
        if (ps_control[0]) begin
            hi_cnt <= hi_cnt + 1;
            lo_cnt <= 0;
        end else begin
            lo_cnt <= lo_cnt + 1;
            hi_cnt <= 0;
        end
        if (!ps_control[0] && lo_cnt == 2) resp_q <= 1'b0;
        else if (ps_control[0] && resp_mode == 0 && hi_cnt == 9) resp_q <= 1'b1;
        else if (ps_control[0] && resp_mode == 2 && hi_cnt == 48) resp_q <= 1'b1;
    end

    // Monitors sample mid-cycle.
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];
    logic [31:0]       out_log [$];
    int                done_cnt = 0;
    int                ctl_hi = 0;
    logic              mv_seen = 1'b0;
    logic              done_err;

    always @(negedge clk) begin
        if (in_wren == 4'hF) begin
            wr_addr_q.push_back(in_addr);
            wr_data_q.push_back(in_wdata);
        end
        if (m_valid && m_ready) out_log.push_back(m_data);
        if (m_valid) mv_seen = 1'b1;
        if (done) done_cnt++;
        if (ps_control[0]) ctl_hi++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        out_log.delete();
        mv_seen = 1'b0;
        ctl_hi  = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input bit gap);
        int guard = 0;
        s_data  = w;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check_eq("push_bound", 1, 0);
        step();
        s_valid = 1'b0;
        if (gap) step();
    endtask

    task automatic push_all(input bit gap);
        for (int i = 0; i < 4; i++) push_word(in_words[i], gap);
    endtask

    // Leaves time at the negedge where done is high.
    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, done, 1);
        done_err = err;
    endtask

    task automatic verify_job(input string tag, input int exp_outs, input logic exp_err);
        check_eq({tag, "_nwr"}, wr_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr_q.size()) begin
                check_eq($sformatf("%s_wa%0d", tag, i), wr_addr_q[i], 4 * i);
                check_eq($sformatf("%s_wd%0d", tag, i), wr_data_q[i], in_words[i]);
            end
        end
        check_eq({tag, "_nout"}, out_log.size(), exp_outs);
        for (int i = 0; i < exp_outs; i++) begin
            if (i < out_log.size()) check_eq($sformatf("%s_out%0d", tag, i), out_log[i], exp_out[i]);
        end
        check_eq({tag, "_err"}, done_err, exp_err);
    endtask

    initial begin
        int d0, bad, n;
        out_mem    = '{32'h4120_0000, 32'h41A0_0000, 32'hDEAD_0002, 32'hDEAD_0003};
        in_words   = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        exp_out    = '{32'h4120_0000, 32'h41A0_0000};
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_sready", s_ready, 0);
        check_eq("rst_mvalid", m_valid, 0);
        check_eq("rst_wren", in_wren, 0);
        check_eq("rst_ctrl", ps_control, 0);
        check_eq("rst_mdata", m_data, 0);
        check_eq("rst_addr", {in_addr, out_addr}, 0);
        reset = 1'b0;
        step();

        // Nominal job.
        clear_logs();
        d0 = done_cnt;
        pulse_start();
        check_eq("nom_busy", busy, 1);
        push_all(1'b0);
        wait_done("nom");
        step();
        check_eq("nom_idle", busy, 0);
        check_eq("nom_ndone", done_cnt - d0, 1);
        verify_job("nom", 2, 1'b0);

        // Input toggling and output backpressure.
        clear_logs();
        m_ready = 1'b0;
        pulse_start();
        push_all(1'b1);
        n = 0;
        while (!m_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_mvalid", m_valid, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(m_valid && m_data == 32'h4120_0000)) bad++;
        end
        check_eq("bp_hold", bad, 0);
        check_eq("bp_nohs", out_log.size(), 0);
        step();
        m_ready = 1'b1;
        wait_done("bp");
        step();
        verify_job("bp", 2, 1'b0);

        // Timeout: status never rises.
        clear_logs();
        resp_mode = 1;
        pulse_start();
        push_all(1'b0);
        wait_done("to");
        step();
        check_eq("to_ctl_cycles", ctl_hi, 50);
        check_eq("to_no_mvalid", mv_seen, 0);
        verify_job("to", 0, 1'b1);
        resp_mode = 0;
        clear_logs();
        pulse_start();
        check_eq("to_err_clear", err, 0);
        push_all(1'b0);
        wait_done("to2");
        step();
        verify_job("to2", 2, 1'b0);

        // Stale status at start.
        stale_force = 1'b1;
        step();
        d0 = done_cnt;
        pulse_start();
        check_eq("stale_sready", s_ready, 0);
        check_eq("stale_busy", busy, 0);
        check_eq("stale_err", err, 1);
        check_eq("stale_done", done, 1);
        step();
        check_eq("stale_done_pulse", done, 0);
        check_eq("stale_ndone", done_cnt - d0, 1);
        stale_force = 1'b0;
        step();

        // Reset during RD_OUT, then a fresh job.
        clear_logs();
        m_ready = 1'b0;
        pulse_start();
        push_all(1'b0);
        n = 0;
        while (!m_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("mr_mvalid", m_valid, 1);
        step();
        d0 = done_cnt;
        reset = 1'b1;
        step();
        check_eq("mr_ctrl", ps_control, 0);
        check_eq("mr_mvalid0", m_valid, 0);
        check_eq("mr_busy", busy, 0);
        reset = 1'b0;
        m_ready = 1'b1;
        repeat (6) step();
        check_eq("mr_nodone", done_cnt - d0, 0);
        clear_logs();
        pulse_start();
        push_all(1'b0);
        wait_done("mr2");
        step();
        verify_job("mr2", 2, 1'b0);

        // Start ignored in LOAD and DONE; status rises on the timeout cycle.
        clear_logs();
        resp_mode = 2;
        d0 = done_cnt;
        pulse_start();
        pulse_start();
        push_all(1'b0);
        wait_done("tie");
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        check_eq("tie_idle", busy, 0);
        check_eq("tie_ndone", done_cnt - d0, 1);
        verify_job("tie", 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
